// File: rtl/load_store_unit.sv
// Load/store sequencer in front of a small byte memory: forms base+offset,
// drives level-sensitive rd/wr strobes with setup/hold cycles, returns data or fault.
module load_store_unit #(
    parameter int ADDR_W        = 5,
    parameter int STROBE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [7:0]        req_base,
    input  logic [3:0]        req_offset,
    input  logic [7:0]        req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [7:0]        resp_rdata,
    output logic              resp_fault,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // req_ready is high only while idle, resp_valid holds with stable data until resp_ready.

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RESP} state_t;

    state_t     state;
    logic [3:0] strobe_cnt;
    logic       is_store;
    logic [7:0] eff;
    logic       eff_fault;

    // 8-bit wrap-around sum; any bit above the memory range marks a fault
    assign eff       = req_base + {{4{req_offset[3]}}, req_offset};
    assign eff_fault = (eff >> ADDR_W) != 8'd0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 8'd0;
            resp_fault <= 1'b0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 8'd0;
            strobe_cnt <= 4'd0;
            is_store   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready  <= 1'b0;
                        resp_rdata <= 8'd0;
                        is_store   <= req_we;
                        if (eff_fault) begin
                            resp_fault <= 1'b1;
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end else begin
                            resp_fault <= 1'b0;
                            mem_addr   <= eff[ADDR_W-1:0];
                            if (req_we) begin
                                mem_wdata <= req_wdata;
                            end
                            state <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    mem_rd     <= !is_store;
                    mem_wr     <= is_store;
                    strobe_cnt <= 4'(STROBE_CYCLES - 1);
                    state      <= STROBE;
                end
                STROBE: begin
                    if (strobe_cnt == 4'd0) begin
                        // closing edge of the last strobe cycle: sample the memory
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                        if (!is_store) begin
                            resp_rdata <= mem_rdata;
                        end
                        state <= HOLD;
                    end else begin
                        strobe_cnt <= strobe_cnt - 4'd1;
                    end
                end
                HOLD: begin
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: two instances (1- and 3-cycle strobes), each with a
// byte memory, checked against a table of vectors and a byte-array reference model.
module tb_load_store_unit;
    localparam int ADDR_W   = 5;
    localparam int MEM_SIZE = 1 << ADDR_W;
    localparam int SC0      = 1;
    localparam int SC1      = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic do_preload;
    logic [1:0] req_valid, req_ready, req_we, resp_valid, resp_ready, resp_fault, mem_rd, mem_wr;
    logic [7:0] req_base [2];
    logic [7:0] req_wdata [2];
    logic [7:0] resp_rdata [2];
    logic [7:0] mem_wdata [2];
    logic [7:0] mem_rdata [2];
    logic [3:0] req_offset [2];
    logic [ADDR_W-1:0] mem_addr [2];
    logic [7:0] mem [2][MEM_SIZE];
    logic [7:0] ref_mem [2][MEM_SIZE];

    int tests = 0;
    int failed = 0;

    bit         pend_we;
    logic [7:0] pend_base, pend_wd;
    logic [3:0] pend_off;

    typedef struct {
        bit         we;
        logic [7:0] base;
        logic [3:0] off;
        logic [7:0] wd;
        logic       fault;
        logic [7:0] rdata;
        int         addr;
    } vec_t;
    vec_t vecs[10];

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(ADDR_W), .STROBE_CYCLES(SC0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_base(req_base[0]), .req_offset(req_offset[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_fault(resp_fault[0]),
        .mem_rd(mem_rd[0]), .mem_wr(mem_wr[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
    );

    load_store_unit #(.ADDR_W(ADDR_W), .STROBE_CYCLES(SC1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_base(req_base[1]), .req_offset(req_offset[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_fault(resp_fault[1]),
        .mem_rd(mem_rd[1]), .mem_wr(mem_wr[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
    );

    // Level-sensitive byte memory: write while mem_wr is high at an edge, async read
    function automatic logic [7:0] init_byte(input int d, input int i);
        if (d != 0) return 8'h00;
        case (i)
            0: return 8'h08;
            1: return 8'h02;
            2: return 8'h01;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (do_preload) begin
                for (int i = 0; i < MEM_SIZE; i++) mem[d][i] <= init_byte(d, i);
            end else if (mem_wr[d]) begin
                mem[d][mem_addr[d]] <= mem_wdata[d];
            end
        end
    end
    assign mem_rdata[0] = mem[0][mem_addr[0]];
    assign mem_rdata[1] = mem[1][mem_addr[1]];

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s dut%0d: got %0h expected %0h", name, d, act, exp);
        end
    endtask

    // Reference: byte array plus plain signed arithmetic on the effective address
    task automatic model(input int d, input bit we, input logic [7:0] base, input logic [3:0] off,
                         input logic [7:0] wd, output logic fault, output logic [7:0] rdata,
                         output int addr);
        int o, e;
        o = off[3] ? int'(off) - 16 : int'(off);
        e = (int'(base) + o + 256) % 256;
        fault = (e >= MEM_SIZE);
        rdata = 8'h00;
        addr  = e;
        if (!fault) begin
            if (we) ref_mem[d][e] = wd;
            else    rdata = ref_mem[d][e];
        end
    endtask

    task automatic issue(input int d, input bit we, input logic [7:0] base, input logic [3:0] off,
                         input logic [7:0] wd, input bit predriven);
        if (!predriven) begin
            @(negedge clk);
            req_valid[d] = 1'b1;
            req_we[d] = we;
            req_base[d] = base;
            req_offset[d] = off;
            req_wdata[d] = wd;
        end
        check("req_ready_idle", d, 32'(req_ready[d]), 32'd1);
        @(posedge clk);
    endtask

    task automatic finish(input int d, input bit we, input logic [7:0] wd, input logic exp_fault,
                          input logic [7:0] exp_rdata, input int exp_addr, input int bp);
        int sc, lat, rd_n, wr_n, first, last, addr_bad, wd_bad, both, bad;
        logic [7:0] r;
        logic f;
        sc = (d == 0) ? SC0 : SC1;
        lat = 1; rd_n = 0; wr_n = 0; first = -1; last = -1; addr_bad = 0; wd_bad = 0; both = 0;
        @(negedge clk);
        req_valid[d] = 1'b0;
        req_we[d] = 1'($urandom);
        req_base[d] = 8'($urandom);
        req_offset[d] = 4'($urandom);
        req_wdata[d] = 8'($urandom);
        while (!resp_valid[d] && lat < 40) begin
            if (mem_rd[d]) rd_n++;
            if (mem_wr[d]) wr_n++;
            if (mem_rd[d] && mem_wr[d]) both++;
            if (mem_rd[d] || mem_wr[d]) begin
                if (first < 0) first = lat;
                last = lat;
            end
            if (!exp_fault && mem_addr[d] !== ADDR_W'(exp_addr)) addr_bad++;
            if (!exp_fault && we && mem_wdata[d] !== wd) wd_bad++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("latency", d, 32'(lat), exp_fault ? 32'd1 : 32'(3 + sc));
        check("rd_cycles", d, 32'(rd_n), (!exp_fault && !we) ? 32'(sc) : 32'd0);
        check("wr_cycles", d, 32'(wr_n), (!exp_fault && we) ? 32'(sc) : 32'd0);
        check("strobe_span", d, (first < 0) ? 32'd0 : 32'(last - first + 1), 32'(rd_n + wr_n));
        check("strobe_both", d, 32'(both), 32'd0);
        check("addr_stable", d, 32'(addr_bad), 32'd0);
        check("wdata_stable", d, 32'(wd_bad), 32'd0);
        check("resp_fault", d, 32'(resp_fault[d]), 32'(exp_fault));
        check("resp_rdata", d, 32'(resp_rdata[d]), 32'(exp_rdata));
        r = resp_rdata[d];
        f = resp_fault[d];
        bad = 0;
        if (bp > 0) begin
            req_valid[d] = 1'b1;
            req_we[d] = pend_we;
            req_base[d] = pend_base;
            req_offset[d] = pend_off;
            req_wdata[d] = pend_wd;
        end
        repeat (bp) begin
            @(posedge clk);
            @(negedge clk);
            if (!resp_valid[d] || resp_rdata[d] !== r || resp_fault[d] !== f ||
                req_ready[d] || mem_rd[d] || mem_wr[d]) bad++;
        end
        if (bp > 0) check("backpressure_hold", d, 32'(bad), 32'd0);
        resp_ready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready[d] = 1'b0;
        check("resp_done", d, {30'd0, resp_valid[d], req_ready[d]}, 32'd1);
    endtask

    task automatic run_random(input int d, input int n);
        bit cur_we;
        logic [7:0] cur_base, cur_wd, er;
        logic [3:0] cur_off;
        logic ef;
        int ea, bp;
        bit pre;
        pre = 1'b0;
        cur_we = 1'($urandom_range(0, 1));
        cur_base = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, MEM_SIZE + 3));
        cur_off = 4'($urandom_range(0, 15));
        cur_wd = 8'($urandom);
        for (int i = 0; i < n; i++) begin
            issue(d, cur_we, cur_base, cur_off, cur_wd, pre);
            model(d, cur_we, cur_base, cur_off, cur_wd, ef, er, ea);
            pend_we = 1'($urandom_range(0, 1));
            pend_base = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, MEM_SIZE + 3));
            pend_off = 4'($urandom_range(0, 15));
            pend_wd = 8'($urandom);
            bp = (i == n - 1) ? 0 : $urandom_range(0, 3);
            finish(d, cur_we, cur_wd, ef, er, ea, bp);
            pre = (bp > 0);
            cur_we = pend_we; cur_base = pend_base; cur_off = pend_off; cur_wd = pend_wd;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ef;
        logic [7:0] er;
        int ea, cnt;

        vecs[0] = '{1'b0, 8'h01, 4'h1, 8'h00, 1'b0, 8'h01, 2};
        vecs[1] = '{1'b1, 8'h10, 4'hF, 8'hA5, 1'b0, 8'h00, 15};
        vecs[2] = '{1'b0, 8'h0F, 4'h0, 8'h00, 1'b0, 8'hA5, 15};
        vecs[3] = '{1'b0, 8'h1F, 4'h1, 8'h00, 1'b1, 8'h00, 32};
        vecs[4] = '{1'b0, 8'h00, 4'hF, 8'h00, 1'b1, 8'h00, 255};
        vecs[5] = '{1'b1, 8'h1F, 4'h0, 8'h3C, 1'b0, 8'h00, 31};
        vecs[6] = '{1'b0, 8'h18, 4'h7, 8'h00, 1'b0, 8'h3C, 31};
        vecs[7] = '{1'b0, 8'h08, 4'h8, 8'h00, 1'b0, 8'h08, 0};
        vecs[8] = '{1'b1, 8'h7F, 4'h1, 8'h5A, 1'b1, 8'h00, 128};
        vecs[9] = '{1'b0, 8'h20, 4'hF, 8'h00, 1'b0, 8'h3C, 31};

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < MEM_SIZE; i++) ref_mem[d][i] = init_byte(d, i);
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_base[d] = 8'h00;
            req_offset[d] = 4'h0; req_wdata[d] = 8'h00; resp_ready[d] = 1'b0;
        end
        rst_n = 1'b0;
        do_preload = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("reset_ctrl", d, {27'd0, req_ready[d], resp_valid[d], resp_fault[d], mem_rd[d], mem_wr[d]}, 32'h10);
            check("reset_data", d, {11'd0, resp_rdata[d], mem_wdata[d], mem_addr[d]}, 32'd0);
        end
        rst_n = 1'b1;
        do_preload = 1'b0;

        for (int i = 0; i < 10; i++) begin
            issue(0, vecs[i].we, vecs[i].base, vecs[i].off, vecs[i].wd, 1'b0);
            model(0, vecs[i].we, vecs[i].base, vecs[i].off, vecs[i].wd, ef, er, ea);
            finish(0, vecs[i].we, vecs[i].wd, vecs[i].fault, vecs[i].rdata, vecs[i].addr, 0);
        end

        // Backpressure: a store is held on the request port during 5 stalled cycles
        pend_we = 1'b1; pend_base = 8'h05; pend_off = 4'h0; pend_wd = 8'h5E;
        issue(0, 1'b0, 8'h01, 4'h1, 8'h00, 1'b0);
        model(0, 1'b0, 8'h01, 4'h1, 8'h00, ef, er, ea);
        finish(0, 1'b0, 8'h00, ef, er, ea, 5);
        issue(0, 1'b1, 8'h05, 4'h0, 8'h5E, 1'b1);
        model(0, 1'b1, 8'h05, 4'h0, 8'h5E, ef, er, ea);
        finish(0, 1'b1, 8'h5E, ef, er, ea, 0);
        issue(0, 1'b0, 8'h06, 4'hF, 8'h00, 1'b0);
        model(0, 1'b0, 8'h06, 4'hF, 8'h00, ef, er, ea);
        finish(0, 1'b0, 8'h00, ef, er, ea, 0);

        // Three-cycle strobe instance
        issue(1, 1'b1, 8'h07, 4'h0, 8'h99, 1'b0);
        model(1, 1'b1, 8'h07, 4'h0, 8'h99, ef, er, ea);
        finish(1, 1'b1, 8'h99, ef, er, ea, 0);
        issue(1, 1'b0, 8'h09, 4'hE, 8'h00, 1'b0);
        model(1, 1'b0, 8'h09, 4'hE, 8'h00, ef, er, ea);
        finish(1, 1'b0, 8'h00, ef, er, ea, 0);
        issue(1, 1'b0, 8'hE0, 4'h0, 8'h00, 1'b0);
        model(1, 1'b0, 8'hE0, 4'h0, 8'h00, ef, er, ea);
        finish(1, 1'b0, 8'h00, ef, er, ea, 0);

        run_random(0, 30);
        run_random(1, 10);

        // Reset during a store's strobe cycle; address 3 is not read afterwards
        issue(0, 1'b1, 8'h03, 4'h0, 8'hEE, 1'b0);
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midreset_strobe_on", 0, 32'(mem_wr[0]), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midreset_ctrl", 0, {27'd0, req_ready[0], resp_valid[0], resp_fault[0], mem_rd[0], mem_wr[0]}, 32'h10);
        check("midreset_data", 0, {11'd0, resp_rdata[0], mem_wdata[0], mem_addr[0]}, 32'd0);
        rst_n = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            if (resp_valid[0] || mem_rd[0] || mem_wr[0]) cnt++;
        end
        check("midreset_no_resp", 0, 32'(cnt), 32'd0);
        issue(0, 1'b0, 8'h02, 4'h0, 8'h00, 1'b0);
        model(0, 1'b0, 8'h02, 4'h0, 8'h00, ef, er, ea);
        finish(0, 1'b0, 8'h00, ef, er, ea, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
